// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: the raw button input and the debounced outputs.
// With DEBOUNCE_LONGPRESS_EN defined, the bundle also carries the long_press flag.
interface button_debouncer_if;
    logic raw_btn;
    logic btn_level;
    logic btn_changed;
`ifdef DEBOUNCE_LONGPRESS_EN
    logic long_press;

    modport master (output raw_btn, input btn_level, input btn_changed, input long_press);
    modport slave  (input raw_btn, output btn_level, output btn_changed, output long_press);
`else
    modport master (output raw_btn, input btn_level, input btn_changed);
    modport slave  (input raw_btn, output btn_level, output btn_changed);
`endif
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: a 2-FF synchronizer feeds a counter-qualified press/release FSM.
// Optional held-button flag when DEBOUNCE_LONGPRESS_EN is defined.
module button_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    button_debouncer_if.slave btn
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

    if (STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_chk
        $error("button_debouncer: STABLE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic          s1_q, s2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          changed_q, changed_d;
    logic          accept_press, accept_release;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= btn.raw_btn;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            changed_q <= changed_d;
        end
    end

    // Any opposite sample in a CHK state falls back, so qualification restarts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (s2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s2_q)                state_d = RELEASED;
                else if (cnt_q == CNT_MAX) state_d = PRESSED;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (s2_q)                 state_d = PRESSED;
                else if (cnt_q == CNT_MAX) state_d = RELEASED;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = RELEASED;
        endcase
    end

    always_comb begin
        accept_press   = (state_q == PRESS_CHK)   && (state_d == PRESSED);
        accept_release = (state_q == RELEASE_CHK) && (state_d == RELEASED);
        level_d        = level_q;
        changed_d      = 1'b0;
        if (accept_press) begin
            level_d   = 1'b1;
            changed_d = 1'b1;
        end
        if (accept_release) begin
            level_d   = 1'b0;
            changed_d = 1'b1;
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_changed = changed_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_press_q, long_press_d;
    logic          held;

    always_comb begin
        held         = (state_q == PRESSED) || (state_q == RELEASE_CHK);
        long_cnt_d   = long_cnt_q;
        long_press_d = long_press_q;
        if (accept_press)
            long_cnt_d = '0;
        else if (held && long_cnt_q != LONG_MAX)
            long_cnt_d = long_cnt_q + 1'b1;
        if (held && long_cnt_d == LONG_MAX)
            long_press_d = 1'b1;
        // A rejected release bounce leaves the flag alone; only an accepted release clears it.
        if (accept_release)
            long_press_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= long_press_d;
        end
    end

    assign btn.long_press = long_press_q;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, LONG_CYCLES=10.
// Long-press sequences run only when DEBOUNCE_LONGPRESS_EN is defined.
module tb_button_debouncer;
    localparam int STABLE = 4;
    localparam int LONG   = 10;

    typedef struct {
        logic rst_n;
        logic raw;
        logic exp_level;
        logic exp_changed;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    button_debouncer_if bif();

    button_debouncer #(.STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic raw, input logic l, input logic c);
        vec_t v;
        v.rst_n = r; v.raw = raw; v.exp_level = l; v.exp_changed = c;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%b expected=%b", name, idx, act, exp);
        end
    endtask

    // Drive inputs, take one posedge, then sample just after it.
    task automatic step(input logic r, input logic raw);
        rst_n       = r;
        bif.raw_btn = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic raw);
        for (int i = 0; i < 12; i++) step(1'b1, raw);
    endtask

    initial begin
        int pulses;
        rst_n       = 1'b0;
        bif.raw_btn = 1'b0;

        // reset, idle, clean press, clean release, chatter
        add(0, 0, 0, 0); add(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 0, 0, 0);
        for (int k = 0; k <= 10; k++) add(1, 1, k >= 6, k == 6);
        for (int k = 0; k <= 10; k++) add(1, 0, k < 6, k == 6);
        for (int r = 0; r < 5; r++)
            for (int j = 0; j < 5; j++) add(1, j < 3, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].raw);
            chk("vec_level", i, bif.btn_level, vecs[i].exp_level);
            chk("vec_changed", i, bif.btn_changed, vecs[i].exp_changed);
`ifdef DEBOUNCE_LONGPRESS_EN
            chk("vec_long", i, bif.long_press, 1'b0);
`endif
        end

        // release with a one-cycle high glitch at edge 2
        settle(1'b1);
        chk("glitch_pre_level", 0, bif.btn_level, 1'b1);
        pulses = 0;
        for (int e = 0; e < 16; e++) begin
            step(1'b1, e == 2);
            chk("glitch_level", e, bif.btn_level, e < 9);
            chk("glitch_changed", e, bif.btn_changed, e == 9);
            if (bif.btn_changed) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL glitch_pulse_count got=%0d expected=1", pulses);
        end

        // reset while pressed with the button still held
        settle(1'b1);
        chk("rst_pre_level", 0, bif.btn_level, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_level", 0, bif.btn_level, 1'b0);
        chk("rst_changed", 0, bif.btn_changed, 1'b0);
        for (int e = 0; e < 10; e++) begin
            step(1'b1, 1'b1);
            chk("rst_requal_level", e, bif.btn_level, e >= 6);
            chk("rst_requal_changed", e, bif.btn_changed, e == 6);
        end

`ifdef DEBOUNCE_LONGPRESS_EN
        settle(1'b0);
        chk("lp_idle", 0, bif.long_press, 1'b0);
        for (int e = 0; e < 30; e++) begin
            step(1'b1, 1'b1);
            chk("lp_hold_level", e, bif.btn_level, e >= 6);
            chk("lp_hold_long", e, bif.long_press, e >= 6 + LONG);
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b1, e >= 2);
            chk("lp_bounce_level", e, bif.btn_level, 1'b1);
            chk("lp_bounce_long", e, bif.long_press, 1'b1);
            chk("lp_bounce_changed", e, bif.btn_changed, 1'b0);
        end
        for (int e = 0; e < 10; e++) begin
            step(1'b1, 1'b0);
            chk("lp_rel_level", e, bif.btn_level, e < 6);
            chk("lp_rel_long", e, bif.long_press, e < 6);
            chk("lp_rel_changed", e, bif.btn_changed, e == 6);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
